// File: rtl/vcnt_sched_pkg.sv
// rtl/vcnt_sched_pkg.sv - shared state and direction encodings for vcnt_sched
// Purpose: FSM state encodings and counting-direction constants shared by
//          the scheduler and its bench.
package vcnt_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b0;  // clear, count up from 0
  localparam logic DIR_DOWN = 1'b1;  // set, count down from SET_VALUE

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin arbiter
// Purpose: picks the first set request at or after ptr_i, wrapping.
// Ports:
//   req_i   - request vector
//   ptr_i   - priority pointer (index that ranks first)
//   gnt_o   - one-hot grant, zero when no request
//   idx_o   - encoded index of the grant
//   valid_o - any request present
module rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [2*N_REQ-1:0] rot;
  int                 k;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    k       = 0;
    // Rotating the doubled vector puts ptr_i at bit 0, so a plain
    // lowest-set-bit search gives the wrapped round-robin winner.
    rot = {req_i, req_i} >> ptr_i;
    for (int i = 0; i < N_REQ; i++) begin
      if (!valid_o && rot[i]) begin
        valid_o = 1'b1;
        k       = int'(ptr_i) + i;
        if (k >= N_REQ) k = k - N_REQ;
        idx_o   = IDX_W'(k);
      end
    end
    if (valid_o) gnt_o = {{(N_REQ-1){1'b0}}, 1'b1} << idx_o;
  end

endmodule

// File: rtl/vcnt.sv
// rtl/vcnt.sv - versatile up/down counter with clear and set
// Purpose: counter shared by vcnt_sched clients.
// Ports:
//   clk_i, rst_ni - clock, async active-low reset
//   clear_i       - load 0 next edge (wins over set)
//   set_i         - load SET_VALUE next edge
//   cke_i, rew_i  - count enable, count down when rew_i=1
//   q_o           - counter value
module vcnt #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             set_i,
  input  logic             cke_i,
  input  logic             rew_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      q_q <= '0;
    else if (clear_i) q_q <= '0;
    else if (set_i)   q_q <= SET_VALUE;
    else if (cke_i)   q_q <= rew_i ? q_q - 1'b1 : q_q + 1'b1;
  end

  assign q_o = q_q;

endmodule

// File: rtl/vcnt_sched.sv
// rtl/vcnt_sched.sv - round-robin scheduler sharing one vcnt among requesters
// Purpose: grants the counter to one requester at a time, loads it, runs it
//          to the requester's terminal value and pulses done.
// Ports:
//   clk_i, rst_ni    - clock, async active-low reset
//   req_i            - per-requester request level
//   len_i            - per-requester interval length, slice i*WIDTH
//   dir_i            - per-requester direction (0 up, 1 down)
//   gnt_o            - one-hot owner
//   done_o           - completion pulse to owner
//   busy_o           - scheduler not idle
//   cnt_clear_o/cnt_set_o/cnt_cke_o/cnt_rew_o - counter controls
//   cnt_q_i          - counter value
module vcnt_sched
  import vcnt_sched_pkg::*;
#(
  parameter int               N_REQ     = 4,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] len_i,
  input  logic [N_REQ-1:0]       dir_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   busy_o,
  output logic                   cnt_clear_o,
  output logic                   cnt_set_o,
  output logic                   cnt_cke_o,
  output logic                   cnt_rew_o,
  input  logic [WIDTH-1:0]       cnt_q_i
);

  localparam int IDX_W = $clog2(N_REQ);

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
    if (int'(idx) == N_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, rr_ptr_q, rr_ptr_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic             busy_q, rew_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic [WIDTH-1:0] sel_len;
  logic             owner_req;

  rr_arb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign sel_len   = len_i[arb_idx*WIDTH +: WIDTH];
  assign owner_req = req_i[idx_q];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dir_d       = dir_q;
    term_d      = term_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    cnt_clear_o = 1'b0;
    cnt_set_o   = 1'b0;
    cnt_cke_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          idx_d   = arb_idx;
          dir_d   = dir_i[arb_idx];
          // Down intervals clamp at 0 so the counter never wraps.
          term_d  = (dir_i[arb_idx] == DIR_DOWN)
                  ? SET_VALUE - ((sel_len > SET_VALUE) ? SET_VALUE : sel_len)
                  : sel_len;
          gnt_d   = arb_gnt;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD, ST_RUN: begin
        if (!owner_req) begin
          // Abort: controls stay low, counter keeps its value.
          gnt_d    = '0;
          rr_ptr_d = ptr_after(idx_q);
          state_d  = ST_IDLE;
        end else if (state_q == ST_LOAD) begin
          cnt_clear_o = (dir_q == DIR_UP);
          cnt_set_o   = (dir_q == DIR_DOWN);
          state_d     = ST_RUN;
        end else if (cnt_q_i == term_q) begin
          gnt_d   = '0;
          done_d  = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;
          state_d = ST_DONE;
        end else begin
          cnt_cke_o = 1'b1;
        end
      end
      ST_DONE: begin
        rr_ptr_d = ptr_after(idx_q);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Direction only matters in RUN; elsewhere the last value is held.
  assign cnt_rew_o = (state_q == ST_RUN) ? dir_q : rew_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      dir_q    <= 1'b0;
      term_q   <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      rew_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dir_q    <= dir_d;
      term_q   <= term_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= (state_d != ST_IDLE);
      rew_q    <= cnt_rew_o;
    end
  end

  assign gnt_o  = gnt_q;
  assign done_o = done_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_vcnt_sched.sv
// tb/tb_vcnt_sched.sv - self-checking bench for vcnt_sched with a real vcnt
module tb_vcnt_sched;
  import vcnt_sched_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] len = '0;
  logic [N-1:0]   dir = '0;
  logic [N-1:0]   gnt, done;
  logic           busy, c_clear, c_set, c_cke, c_rew;
  logic [W-1:0]   q;

  vcnt_sched #(.N_REQ(N), .WIDTH(W), .SET_VALUE(8'hFF)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .len_i(len), .dir_i(dir),
    .gnt_o(gnt), .done_o(done), .busy_o(busy),
    .cnt_clear_o(c_clear), .cnt_set_o(c_set), .cnt_cke_o(c_cke),
    .cnt_rew_o(c_rew), .cnt_q_i(q)
  );

  vcnt #(.WIDTH(W), .SET_VALUE(8'hFF)) u_cnt (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(c_clear), .set_i(c_set),
    .cke_i(c_cke), .rew_i(c_rew), .q_o(q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int idx; int cyc;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  exp_t new_e;

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [7:0] l, input logic d);
    req[i]         = 1'b1;
    len[i*W +: W]  = l;
    dir[i]         = d;
  endtask

  task automatic expect_done(input int i, input int c);
    new_e.idx = i;
    new_e.cyc = c;
    sb.push_back(new_e);
  endtask

  // Scoreboard: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (rst_n && done != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_idx", 32'(done), 32'd1 << mon_e.idx);
        check("done_cyc", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  int t0;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_gnt", 32'(gnt), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_clear", 32'(c_clear), 32'd0);
    check("idle_set", 32'(c_set), 32'd0);
    check("idle_cke", 32'(c_cke), 32'd0);
    check("idle_rew", 32'(c_rew), 32'd0);

    // Up interval, len 5
    t0 = cyc; set_req(0, 8'd5, DIR_UP); expect_done(0, t0 + 8);
    wait_to(t0 + 1);
    check("up_clear", 32'(c_clear), 32'd1);
    check("up_set", 32'(c_set), 32'd0);
    check("up_gnt", 32'(gnt), 32'h1);
    check("up_busy", 32'(busy), 32'd1);
    wait_to(t0 + 2);
    check("up_q0", 32'(q), 32'd0);
    check("up_cke", 32'(c_cke), 32'd1);
    wait_to(t0 + 7);
    check("up_q5", 32'(q), 32'd5);
    check("up_cke_end", 32'(c_cke), 32'd0);
    wait_to(t0 + 8);
    check("up_gnt_done", 32'(gnt), 32'd0);
    req[0] = 1'b0;
    wait_to(t0 + 9);
    check("up_busy_fall", 32'(busy), 32'd0);

    // Down interval, len 3
    t0 = cyc; set_req(2, 8'd3, DIR_DOWN); expect_done(2, t0 + 6);
    wait_to(t0 + 1);
    check("dn_set", 32'(c_set), 32'd1);
    check("dn_clear", 32'(c_clear), 32'd0);
    wait_to(t0 + 2);
    check("dn_qff", 32'(q), 32'hFF);
    check("dn_rew", 32'(c_rew), 32'd1);
    check("dn_cke", 32'(c_cke), 32'd1);
    wait_to(t0 + 5);
    check("dn_qfc", 32'(q), 32'hFC);
    check("dn_cke_end", 32'(c_cke), 32'd0);
    wait_to(t0 + 6); req[2] = 1'b0;
    wait_to(t0 + 7);

    // Full-range countdown
    t0 = cyc; set_req(2, 8'hFF, DIR_DOWN); expect_done(2, t0 + 258);
    wait_to(t0 + 257);
    check("dnff_q0", 32'(q), 32'd0);
    check("dnff_cke", 32'(c_cke), 32'd0);
    wait_to(t0 + 258); req[2] = 1'b0;
    wait_to(t0 + 259);

    // Zero length
    t0 = cyc; set_req(1, 8'd0, DIR_UP); expect_done(1, t0 + 3);
    wait_to(t0 + 2);
    check("len0_cke", 32'(c_cke), 32'd0);
    check("len0_q", 32'(q), 32'd0);
    wait_to(t0 + 3); req[1] = 1'b0;
    wait_to(t0 + 4);

    // len changed during RUN must not move the terminal value
    t0 = cyc; set_req(3, 8'd4, DIR_UP); expect_done(3, t0 + 7);
    wait_to(t0 + 3); len[3*W +: W] = 8'd1;
    wait_to(t0 + 4);
    check("lchg_q2", 32'(q), 32'd2);
    check("lchg_cke", 32'(c_cke), 32'd1);
    wait_to(t0 + 6);
    check("lchg_q4", 32'(q), 32'd4);
    wait_to(t0 + 7); req[3] = 1'b0;
    wait_to(t0 + 8);

    // Fairness: all requesting, pointer at 0
    t0 = cyc;
    for (int i = 0; i < N; i++) set_req(i, 8'd1, DIR_UP);
    for (int k = 0; k < 5; k++) expect_done(k % N, t0 + 4 + 5 * k);
    for (int k = 0; k < 5; k++) begin
      wait_to(t0 + 1 + 5 * k);
      check("fair_gnt", 32'(gnt), 32'd1 << (k % N));
    end
    wait_to(t0 + 24); req = '0;
    wait_to(t0 + 25);

    // Abort of requester 1 in its third RUN cycle; pointer at 1
    t0 = cyc; set_req(1, 8'd10, DIR_UP); set_req(2, 8'd2, DIR_UP);
    expect_done(2, t0 + 10);
    wait_to(t0 + 4);
    check("abort_cke_pre", 32'(c_cke), 32'd1);
    req[1] = 1'b0;
    #1;
    check("abort_cke", 32'(c_cke), 32'd0);
    check("abort_clear", 32'(c_clear), 32'd0);
    wait_to(t0 + 5);
    check("abort_busy", 32'(busy), 32'd0);
    wait_to(t0 + 6);
    check("abort_next_gnt", 32'(gnt), 32'h4);
    wait_to(t0 + 10); req[2] = 1'b0;
    wait_to(t0 + 11);

    // Async reset during RUN
    t0 = cyc; set_req(0, 8'd20, DIR_UP);
    wait_to(t0 + 4);
    check("rstrun_cke_pre", 32'(c_cke), 32'd1);
    rst_n = 1'b0; req[0] = 1'b0;
    #1;
    check("rstrun_gnt", 32'(gnt), 32'd0);
    check("rstrun_busy", 32'(busy), 32'd0);
    check("rstrun_cke", 32'(c_cke), 32'd0);
    wait_to(t0 + 5); rst_n = 1'b1;
    wait_to(t0 + 6);

    // Pointer back at 0: requester 1 beats 3, then 3 is served
    t0 = cyc; set_req(1, 8'd0, DIR_UP); set_req(3, 8'd0, DIR_UP);
    expect_done(1, t0 + 3); expect_done(3, t0 + 7);
    wait_to(t0 + 1);
    check("post_rst_gnt", 32'(gnt), 32'h2);
    wait_to(t0 + 3); req[1] = 1'b0;
    wait_to(t0 + 5);
    check("post_rst_gnt2", 32'(gnt), 32'h8);
    wait_to(t0 + 7); req[3] = 1'b0;
    wait_to(t0 + 9);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
